// File: rtl/i_cache_assoc.sv
// Two-way set-associative read-only instruction cache with multi-word lines and 1-bit LRU.
// Optional macro ICACHE_UNCACHED_EN: kseg1 fetches (addr[31:29] == 3'b101) bypass the arrays.
module i_cache_assoc #(
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_inst_req,
  input  logic        cpu_inst_wr,
  input  logic [1:0]  cpu_inst_size,
  input  logic [31:0] cpu_inst_addr,
  input  logic [31:0] cpu_inst_wdata,
  output logic [31:0] cpu_inst_rdata,
  output logic        cpu_inst_addr_ok,
  output logic        cpu_inst_data_ok,
  output logic        cache_inst_req,
  output logic        cache_inst_wr,
  output logic [1:0]  cache_inst_size,
  output logic [31:0] cache_inst_addr,
  output logic [31:0] cache_inst_wdata,
  input  logic [31:0] cache_inst_rdata,
  input  logic        cache_inst_addr_ok,
  input  logic        cache_inst_data_ok
);
  localparam int TAG_WIDTH  = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int SETS       = 2 ** INDEX_WIDTH;
  localparam int LINE_WORDS = 2 ** (OFFSET_WIDTH - 2);
  localparam int CW         = (OFFSET_WIDTH > 2) ? OFFSET_WIDTH - 2 : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
  state_t state, state_next;

  logic [SETS-1:0]      valid [2];
  logic [SETS-1:0]      lru;
  logic [TAG_WIDTH-1:0] tag_arr [2][SETS];
  logic [31:0]          data_arr [2][SETS][LINE_WORDS];
  logic [31:0]          line_buf [LINE_WORDS];

  logic [TAG_WIDTH-1:0]   tag, tag_save;
  logic [INDEX_WIDTH-1:0] index, index_save;
  logic [CW-1:0]          word, word_save, cnt, bus_word;
  logic                   victim, victim_save, uncached, uncached_save;
  logic                   hit0, hit1, hit, hit_way;
  logic                   ok, bus_req;
  logic [31:0]            line_base;
  logic                   unused;

  assign tag   = cpu_inst_addr[31 -: TAG_WIDTH];
  assign index = cpu_inst_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign word  = CW'(cpu_inst_addr[31:2]) & CW'(LINE_WORDS - 1);

`ifdef ICACHE_UNCACHED_EN
  assign uncached = (cpu_inst_addr[31:29] == 3'b101);
`else
  assign uncached = 1'b0;
`endif

  assign hit0    = valid[0][index] && (tag_arr[0][index] == tag) && !uncached;
  assign hit1    = valid[1][index] && (tag_arr[1][index] == tag) && !uncached;
  assign hit     = hit0 | hit1;
  assign hit_way = hit1;
  // Prefer an empty way (way0 first) so a half-filled set never evicts a live line.
  assign victim  = !valid[0][index] ? 1'b0 : (!valid[1][index] ? 1'b1 : lru[index]);

  assign line_base = {tag_save, index_save, {OFFSET_WIDTH{1'b0}}};
  assign bus_word  = uncached_save ? word_save : cnt;

  assign cache_inst_wr    = 1'b0;
  assign cache_inst_size  = 2'b10;
  assign cache_inst_wdata = 32'h0000_0000;
  assign cache_inst_addr  = line_base | (32'(bus_word) << 2);
  assign cache_inst_req   = bus_req & rst;
  assign cpu_inst_addr_ok = ok & rst;
  assign cpu_inst_data_ok = ok & rst;
  assign unused = ^{cpu_inst_wr, cpu_inst_size, cpu_inst_wdata, cpu_inst_addr[1:0]};

  // State register, refill bookkeeping, valid and LRU bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      tag_save      <= '0;
      index_save    <= '0;
      word_save     <= '0;
      victim_save   <= 1'b0;
      uncached_save <= 1'b0;
      valid[0]      <= '0;
      valid[1]      <= '0;
      lru           <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (cpu_inst_req && hit) begin
            lru[index] <= ~hit_way;
          end else if (cpu_inst_req) begin
            tag_save      <= tag;
            index_save    <= index;
            word_save     <= word;
            victim_save   <= victim;
            uncached_save <= uncached;
            cnt           <= '0;
          end
        end
        WAIT: begin
          if (cache_inst_data_ok && !uncached_save && (cnt != CW'(LINE_WORDS - 1)))
            cnt <= cnt + CW'(1);
        end
        RESP: begin
          valid[victim_save][index_save] <= 1'b1;
          lru[index_save]                <= ~victim_save;
        end
        default: ;
      endcase
    end
  end

  // Line buffer capture and array install; these arrays carry no reset.
  always_ff @(posedge clk) begin
    if (rst && state == WAIT && cache_inst_data_ok && !uncached_save)
      line_buf[cnt] <= cache_inst_rdata;
    if (rst && state == RESP) begin
      tag_arr[victim_save][index_save] <= tag_save;
      for (int i = 0; i < LINE_WORDS; i++)
        data_arr[victim_save][index_save][i] <= line_buf[i];
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_next     = state;
    ok             = 1'b0;
    bus_req        = 1'b0;
    cpu_inst_rdata = 32'h0000_0000;
    case (state)
      IDLE: begin
        if (cpu_inst_req) begin
          if (hit) begin
            ok             = 1'b1;
            cpu_inst_rdata = data_arr[hit_way][index][word];
          end else begin
            state_next = REQ;
          end
        end else begin
          state_next = IDLE;
        end
      end
      REQ: begin
        bus_req = 1'b1;
        if (cache_inst_addr_ok) state_next = WAIT;
        else                    state_next = REQ;
      end
      WAIT: begin
        if (cache_inst_data_ok) begin
          if (uncached_save) begin
            ok             = 1'b1;
            cpu_inst_rdata = cache_inst_rdata;
            state_next     = IDLE;
          end else if (cnt == CW'(LINE_WORDS - 1)) begin
            state_next = RESP;
          end else begin
            state_next = REQ;
          end
        end else begin
          state_next = WAIT;
        end
      end
      RESP: begin
        ok             = 1'b1;
        cpu_inst_rdata = line_buf[word_save];
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_i_cache_assoc.sv
// Randomised bench for i_cache_assoc against a recency-ordered set model and a
// constant-content memory model behind a delay-configurable SRAM-like responder.
module tb_i_cache_assoc;
  localparam int LW = 4;

  logic        clk;
  logic        rst;
  logic        cpu_inst_req;
  logic        cpu_inst_wr;
  logic [1:0]  cpu_inst_size;
  logic [31:0] cpu_inst_addr;
  logic [31:0] cpu_inst_wdata;
  logic [31:0] cpu_inst_rdata;
  logic        cpu_inst_addr_ok;
  logic        cpu_inst_data_ok;
  logic        cache_inst_req;
  logic        cache_inst_wr;
  logic [1:0]  cache_inst_size;
  logic [31:0] cache_inst_addr;
  logic [31:0] cache_inst_wdata;
  logic [31:0] cache_inst_rdata;
  logic        cache_inst_addr_ok;
  logic        cache_inst_data_ok;

  int checks = 0;
  int errors = 0;

  int a_delay = 0;
  int d_delay = 0;
  int bus_reads = 0;
  int addr_hs = 0;
  int overlap = 0;
  logic [31:0] bus_log [$];

  logic [21:0] m_tag [64][2];
  int          m_n   [64];

  i_cache_assoc dut (
    .clk(clk), .rst(rst),
    .cpu_inst_req(cpu_inst_req), .cpu_inst_wr(cpu_inst_wr), .cpu_inst_size(cpu_inst_size),
    .cpu_inst_addr(cpu_inst_addr), .cpu_inst_wdata(cpu_inst_wdata), .cpu_inst_rdata(cpu_inst_rdata),
    .cpu_inst_addr_ok(cpu_inst_addr_ok), .cpu_inst_data_ok(cpu_inst_data_ok),
    .cache_inst_req(cache_inst_req), .cache_inst_wr(cache_inst_wr), .cache_inst_size(cache_inst_size),
    .cache_inst_addr(cache_inst_addr), .cache_inst_wdata(cache_inst_wdata), .cache_inst_rdata(cache_inst_rdata),
    .cache_inst_addr_ok(cache_inst_addr_ok), .cache_inst_data_ok(cache_inst_data_ok)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit is_unc(input logic [31:0] a);
`ifdef ICACHE_UNCACHED_EN
    return a[31:29] == 3'b101;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 64; s++) m_n[s] = 0;
  endfunction

  // Each set holds up to two tags, least recently used first.
  function automatic bit model_access(input logic [31:0] a);
    logic [21:0] t;
    int s;
    if (is_unc(a)) return 1'b0;
    t = a[31:10];
    s = int'(a[9:4]);
    if (m_n[s] > 0 && m_tag[s][m_n[s]-1] == t) return 1'b1;
    if (m_n[s] == 2 && m_tag[s][0] == t) begin
      m_tag[s][0] = m_tag[s][1];
      m_tag[s][1] = t;
      return 1'b1;
    end
    if (m_n[s] < 2) begin
      m_tag[s][m_n[s]] = t;
      m_n[s]++;
    end else begin
      m_tag[s][0] = m_tag[s][1];
      m_tag[s][1] = t;
    end
    return 1'b0;
  endfunction

  function automatic void predict(input logic [31:0] a, output int lat, output int reads);
    bit h;
    h = model_access(a);
    if (h) begin
      lat = 0; reads = 0;
    end else if (is_unc(a)) begin
      lat = a_delay + d_delay + 2; reads = 1;
    end else begin
      lat = 1 + LW * (a_delay + d_delay + 2); reads = LW;
    end
  endfunction

  // SRAM-like bus responder: addr_ok after a_delay cycles of req, data_ok d_delay cycles later.
  initial begin
    int a_cnt;
    int d_cnt;
    bit in_data;
    logic [31:0] lat_addr;
    a_cnt = 0; d_cnt = 0; in_data = 1'b0; lat_addr = 32'h0;
    cache_inst_addr_ok = 1'b0;
    cache_inst_data_ok = 1'b0;
    cache_inst_rdata   = 32'h0;
    forever begin
      @(posedge clk); #1;
      cache_inst_addr_ok = 1'b0;
      cache_inst_data_ok = 1'b0;
      cache_inst_rdata   = $urandom;
      if (!in_data) begin
        if (cache_inst_req === 1'b1) begin
          if (a_cnt >= a_delay) begin
            cache_inst_addr_ok = 1'b1;
            lat_addr = cache_inst_addr;
            bus_log.push_back(cache_inst_addr);
            addr_hs++;
            in_data = 1'b1;
            d_cnt = 0;
            a_cnt = 0;
          end else a_cnt++;
        end else a_cnt = 0;
      end else begin
        if (cache_inst_req === 1'b1) overlap++;
        if (d_cnt >= d_delay) begin
          cache_inst_data_ok = 1'b1;
          cache_inst_rdata   = mem(lat_addr);
          bus_reads++;
          in_data = 1'b0;
        end else d_cnt++;
      end
    end
  end

  task automatic fetch(input logic [31:0] a, output int lat, output logic [31:0] data,
                       output int reads, output int okmis);
    int r0;
    bit done;
    done = 1'b0; lat = -1; data = 32'h0; okmis = 0;
    @(posedge clk); #1;
    cpu_inst_req   = 1'b1;
    cpu_inst_addr  = a;
    cpu_inst_wr    = 1'($urandom);
    cpu_inst_size  = 2'($urandom);
    cpu_inst_wdata = $urandom;
    r0 = bus_reads;
    bus_log.delete();
    for (int c = 0; c < 300 && !done; c++) begin
      #4;
      if (cpu_inst_addr_ok !== cpu_inst_data_ok) okmis++;
      if (cpu_inst_data_ok === 1'b1) begin
        lat = c; data = cpu_inst_rdata; done = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    reads = bus_reads - r0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cpu_inst_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cpu_inst_req = 1'b1; cpu_inst_addr = 32'h0040_0000;
    cpu_inst_wr = 1'b0; cpu_inst_size = 2'b10; cpu_inst_wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #4;
      checks++;
      if ({cache_inst_req, cpu_inst_addr_ok, cpu_inst_data_ok} !== 3'b000) begin
        errors++;
        $display("FAIL reset_outputs req/aok/dok got %b want 000", {cache_inst_req, cpu_inst_addr_ok, cpu_inst_data_ok});
      end
    end
    @(posedge clk); #1;
    cpu_inst_req = 1'b0; rst = 1'b1;
    #4;
    checks++;
    if ({cache_inst_req, cpu_inst_addr_ok, cpu_inst_data_ok} !== 3'b000) begin
      errors++;
      $display("FAIL post_reset_outputs got %b want 000", {cache_inst_req, cpu_inst_addr_ok, cpu_inst_data_ok});
    end
    checks++;
    if ({cache_inst_wr, cache_inst_size, cache_inst_wdata} !== {1'b0, 2'b10, 32'h0}) begin
      errors++;
      $display("FAIL const_outputs got wr=%b size=%b wdata=%h want 0/10/0", cache_inst_wr, cache_inst_size, cache_inst_wdata);
    end
    model_reset();
  endtask

  task automatic test_kseg1();
    int lat, reads, okmis, el, er;
    logic [31:0] data;
    a_delay = 0; d_delay = 0;
    for (int k = 0; k < 2; k++) begin
      predict(32'hBFC0_0000, el, er);
      fetch(32'hBFC0_0000, lat, data, reads, okmis);
      checks++;
      if (lat !== el) begin errors++; $display("FAIL kseg1_lat[%0d] got %0d want %0d", k, lat, el); end
      checks++;
      if (data !== mem(32'hBFC0_0000)) begin errors++; $display("FAIL kseg1_data[%0d] got %h want %h", k, data, mem(32'hBFC0_0000)); end
      checks++;
      if (reads !== er) begin errors++; $display("FAIL kseg1_reads[%0d] got %0d want %0d", k, reads, er); end
      for (int i = 0; i < bus_log.size(); i++) begin
        checks++;
        if (bus_log[i] !== 32'hBFC0_0000 + 32'(i * 4)) begin
          errors++; $display("FAIL kseg1_busaddr[%0d] got %h want %h", i, bus_log[i], 32'hBFC0_0000 + 32'(i * 4));
        end
      end
    end
  endtask

  task automatic test_hits();
    logic [31:0] addrs [3];
    int lat, reads, okmis, el, er;
    logic [31:0] data;
    addrs[0] = 32'h0040_0008; addrs[1] = 32'h0040_0008; addrs[2] = 32'h0040_000C;
    for (int k = 0; k < 3; k++) begin
      predict(addrs[k], el, er);
      fetch(addrs[k], lat, data, reads, okmis);
      checks++;
      if (lat !== ((k == 0) ? 9 : 0)) begin errors++; $display("FAIL hit_lat[%0d] got %0d want %0d", k, lat, (k == 0) ? 9 : 0); end
      checks++;
      if (reads !== er) begin errors++; $display("FAIL hit_reads[%0d] got %0d want %0d", k, reads, er); end
      checks++;
      if (data !== mem(addrs[k])) begin errors++; $display("FAIL hit_data[%0d] got %h want %h", k, data, mem(addrs[k])); end
      checks++;
      if (okmis !== 0) begin errors++; $display("FAIL hit_okpair[%0d] got %0d want 0", k, okmis); end
    end
    idle(1);
  endtask

  task automatic test_lru();
    logic [31:0] addrs [6];
    bit want_hit [6];
    int lat, reads, okmis, el, er;
    logic [31:0] data;
    addrs[0] = 32'h0000_0000; addrs[1] = 32'h0000_0400; addrs[2] = 32'h0000_0000;
    addrs[3] = 32'h0000_0800; addrs[4] = 32'h0000_0004; addrs[5] = 32'h0000_0408;
    want_hit[0] = 0; want_hit[1] = 0; want_hit[2] = 1; want_hit[3] = 0; want_hit[4] = 1; want_hit[5] = 0;
    for (int k = 0; k < 6; k++) begin
      predict(addrs[k], el, er);
      fetch(addrs[k], lat, data, reads, okmis);
      checks++;
      if ((lat == 0) !== want_hit[k]) begin errors++; $display("FAIL lru_hit[%0d] got %0d want %0d", k, lat == 0, want_hit[k]); end
      checks++;
      if (lat !== el) begin errors++; $display("FAIL lru_lat[%0d] got %0d want %0d", k, lat, el); end
      checks++;
      if (data !== mem(addrs[k])) begin errors++; $display("FAIL lru_data[%0d] got %h want %h", k, data, mem(addrs[k])); end
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    int lat, reads, okmis, el, er;
    logic [31:0] data;
    predict(32'h0000_1050, el, er);
    fetch(32'h0000_1050, lat, data, reads, okmis);
    checks++;
    if (lat !== 9 || data !== mem(32'h0000_1050)) begin
      errors++; $display("FAIL b2b_miss got lat=%0d data=%h want lat=9 data=%h", lat, data, mem(32'h0000_1050));
    end
    predict(32'h0000_105C, el, er);
    fetch(32'h0000_105C, lat, data, reads, okmis);
    checks++;
    if (lat !== 0 || reads !== 0) begin errors++; $display("FAIL b2b_hit got lat=%0d reads=%0d want 0/0", lat, reads); end
    checks++;
    if (data !== mem(32'h0000_105C)) begin errors++; $display("FAIL b2b_data got %h want %h", data, mem(32'h0000_105C)); end
    idle(1);
  endtask

  task automatic test_delayed_bus();
    int lat, reads, okmis, el, er;
    logic [31:0] data;
    a_delay = 2; d_delay = 5; overlap = 0;
    predict(32'h0000_3028, el, er);
    fetch(32'h0000_3028, lat, data, reads, okmis);
    checks++;
    if (lat !== 37) begin errors++; $display("FAIL slow_lat got %0d want 37", lat); end
    checks++;
    if (data !== mem(32'h0000_3028)) begin errors++; $display("FAIL slow_data got %h want %h", data, mem(32'h0000_3028)); end
    checks++;
    if (reads !== LW || overlap !== 0) begin errors++; $display("FAIL slow_bus got reads=%0d overlap=%0d want %0d/0", reads, overlap, LW); end
    for (int i = 0; i < bus_log.size(); i++) begin
      checks++;
      if (bus_log[i] !== 32'h0000_3020 + 32'(i * 4)) begin
        errors++; $display("FAIL slow_busaddr[%0d] got %h want %h", i, bus_log[i], 32'h0000_3020 + 32'(i * 4));
      end
    end
    idle(1);
    a_delay = 0; d_delay = 0;
  endtask

  task automatic test_reset_mid_refill();
    int lat, reads, okmis, el, er, hs0;
    logic [31:0] data;
    bit found;
    a_delay = 0; d_delay = 3; found = 1'b0;
    @(posedge clk); #1;
    cpu_inst_req = 1'b1; cpu_inst_addr = 32'h0000_2074;
    hs0 = addr_hs;
    for (int c = 0; c < 100 && !found; c++) begin
      #4;
      if (addr_hs - hs0 == 3 && cache_inst_req === 1'b0) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL midrst_reach got 0 want 1"); end
    @(posedge clk); #1;
    rst = 1'b0; cpu_inst_req = 1'b0;
    #4;
    checks++;
    if ({cache_inst_req, cpu_inst_addr_ok, cpu_inst_data_ok} !== 3'b000) begin
      errors++; $display("FAIL midrst_during got %b want 000", {cache_inst_req, cpu_inst_addr_ok, cpu_inst_data_ok});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #4;
    checks++;
    if ({cache_inst_req, cpu_inst_addr_ok, cpu_inst_data_ok} !== 3'b000) begin
      errors++; $display("FAIL midrst_after got %b want 000", {cache_inst_req, cpu_inst_addr_ok, cpu_inst_data_ok});
    end
    model_reset();
    idle(10);
    d_delay = 0;
    for (int k = 0; k < 2; k++) begin
      predict(32'h0000_2078 - 32'(k * 8), el, er);
      fetch(32'h0000_2078 - 32'(k * 8), lat, data, reads, okmis);
      checks++;
      if (lat !== ((k == 0) ? 9 : 0) || reads !== er) begin
        errors++; $display("FAIL midrst_refetch[%0d] got lat=%0d reads=%0d want %0d/%0d", k, lat, reads, (k == 0) ? 9 : 0, er);
      end
      checks++;
      if (data !== mem(32'h0000_2078 - 32'(k * 8))) begin
        errors++; $display("FAIL midrst_data[%0d] got %h want %h", k, data, mem(32'h0000_2078 - 32'(k * 8)));
      end
    end
    idle(1);
  endtask

  task automatic test_random();
    int lat, reads, okmis, el, er;
    logic [31:0] data, a;
    for (int n = 0; n < 150; n++) begin
      a_delay = $urandom_range(0, 2);
      d_delay = $urandom_range(0, 2);
      a = {20'($urandom_range(0, 3)), 2'b00, 6'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
      if ($urandom_range(0, 7) == 0) a = 32'hBFC0_0000 | (a & 32'h0000_003C);
      predict(a, el, er);
      fetch(a, lat, data, reads, okmis);
      checks++;
      if (lat !== el) begin errors++; $display("FAIL rnd_lat[%0d] addr=%h got %0d want %0d", n, a, lat, el); end
      checks++;
      if (data !== mem(a)) begin errors++; $display("FAIL rnd_data[%0d] addr=%h got %h want %h", n, a, data, mem(a)); end
      checks++;
      if (reads !== er || okmis !== 0) begin
        errors++; $display("FAIL rnd_bus[%0d] addr=%h got reads=%0d okmis=%0d want %0d/0", n, a, reads, okmis, er);
      end
      for (int i = 0; i < bus_log.size(); i++) begin
        checks++;
        if (bus_log[i] !== (is_unc(a) ? a : ((a & 32'hFFFF_FFF0) + 32'(i * 4)))) begin
          errors++; $display("FAIL rnd_busaddr[%0d.%0d] got %h", n, i, bus_log[i]);
        end
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_kseg1();
    test_hits();
    test_lru();
    test_back_to_back();
    test_delayed_bus();
    test_reset_mid_refill();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
